// File: rtl/branch_resolve_pc.sv
// branch_resolve_pc: resolves branch conditions, owns the PC register, runs the start/halt FSM and counts RUN cycles.
// Optional feature macro: BR_LUT_EN (absolute branch targets taken from a writable target table).
module branch_resolve_pc #(
    parameter int PC_W   = 10,
    parameter int CNT_W  = 16,
    parameter int LUT_AW = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic [PC_W-1:0]   StartAddr,
    input  logic              Branch,
    input  logic              Halt,
    input  logic [1:0]        BrCond,
    input  logic [7:0]        BrMux1,
    input  logic [7:0]        BrMux2,
    input  logic [7:0]        BrOffset,
`ifdef BR_LUT_EN
    input  logic              LutWe,
    input  logic [LUT_AW-1:0] LutAddr,
    input  logic [PC_W-1:0]   LutData,
`endif
    output logic [PC_W-1:0]   PC,
    output logic              Taken,
    output logic              Running,
    output logic              Done,
    output logic [CNT_W-1:0]  CycleCount
);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HALT = 2'b10;

    logic [1:0]       r_state;
    logic [PC_W-1:0]  r_pc;
    logic             r_taken;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cond;
    logic             w_take;
    logic [PC_W-1:0]  w_target;

    assign w_cond = (BrCond == 2'b00) ? (BrMux1 == BrMux2) :
                    (BrCond == 2'b01) ? (BrMux1 != BrMux2) :
                    (BrCond == 2'b10) ? (BrMux1 <  BrMux2) : 1'b1;
    assign w_take = Branch && w_cond;

`ifdef BR_LUT_EN
    logic [PC_W-1:0] r_lut [2**LUT_AW];
    logic            w_unused_off;

    assign w_unused_off = ^BrOffset;
    assign w_target     = r_lut[BrOffset[LUT_AW-1:0]];

    // target table: cleared by reset, written in any state; a same-cycle read sees the old entry
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < 2**LUT_AW; i++) r_lut[i] <= '0;
        end else if (LutWe) begin
            r_lut[LutAddr] <= LutData;
        end
    end
`else
    logic [LUT_AW-1:0] w_unused_idx;

    assign w_unused_idx = BrOffset[LUT_AW-1:0];
    assign w_target     = r_pc + {{(PC_W-8){BrOffset[7]}}, BrOffset};
`endif

    // FSM, PC, taken flag and saturating cycle counter; Halt outranks a branch in the same cycle
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_taken <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_cnt   <= (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
            r_taken <= !Halt && w_take;
            r_state <= Halt ? S_HALT : S_RUN;
            r_pc    <= Halt ? r_pc : w_take ? w_target : r_pc + PC_W'(1);
        end else if (Start) begin
            r_state <= S_RUN;
            r_pc    <= StartAddr;
            r_cnt   <= '0;
        end
    end

    assign PC         = r_pc;
    assign Taken      = r_taken;
    assign Running    = (r_state == S_RUN);
    assign Done       = (r_state == S_HALT);
    assign CycleCount = r_cnt;
endmodule
